// File: rtl/palu_pkg.sv
// palu_pkg: shared opcode, register and instruction types
// for the elementary ALU pipeline and its issue unit.
package palu_pkg;

  localparam int RW = 3;

  typedef logic [RW-1:0] reg_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    ONE  = 3'd1,
    ADD  = 3'd2,
    SUB  = 3'd3,
    NAND = 3'd4,
    SRL  = 3'd5,
    CPA  = 3'd6,
    NOT  = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t op;
    reg_t    src1;
    reg_t    src2;
    reg_t    dest;
  } instr_t;

  localparam int IW = $bits(instr_t);

  function automatic logic reads(
    input instr_t i,
    input reg_t   r
  );
    return (i.src1 == r) || (i.src2 == r);
  endfunction

endpackage

// File: rtl/palu_issue_fifo.sv
// palu_issue_fifo: DEPTH x instr_t synchronous FIFO.
// Ports: push/din, pop/head, count, empty.
module palu_issue_fifo
  import palu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        push,
  input  instr_t      din,
  input  logic        pop,
  output instr_t      head,
  output logic [AW:0] count,
  output logic        empty
);

  instr_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          wr;
  logic          rd;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop & ~empty;
  assign wr    = push & (~full | rd);
  assign head  = mem[rptr];

  always_ff @(posedge clock) begin
    if (wr) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/palu_issue.sv
// palu_issue: FIFO-buffered issue to the ALU pipeline with
// RAW bubble, hold, result tracker and issue/bubble counters.
module palu_issue
  import palu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          inValid,
  output logic          inReady,
  input  logic [2:0]    inOpcode,
  input  logic [2:0]    inSrc1,
  input  logic [2:0]    inSrc2,
  input  logic [2:0]    inDest,
  input  logic          hold,
  output logic          stall,
  output logic [2:0]    opcode,
  output logic [2:0]    src1,
  output logic [2:0]    src2,
  output logic [2:0]    dest,
  output logic          resValid,
  output logic [2:0]    resDest,
  output logic [CW-1:0] issueCount,
  output logic [CW-1:0] bubbleCount
);

  localparam int AW = $clog2(DEPTH);

  instr_t      din;
  instr_t      head;
  logic [AW:0] count;
  logic        empty;
  logic        push;
  logic        issue;
  logic        haz;
  logic        bub;

  logic        lastValid;
  reg_t        lastDest;
  logic        s1v;
  reg_t        s1d;
  logic        s2v;
  reg_t        s2d;

  assign din     = {inOpcode, inSrc1, inSrc2, inDest};
  assign inReady = count != (AW+1)'(DEPTH);
  assign push    = inValid & inReady;

  assign haz   = lastValid & reads(head, lastDest);
  assign stall = empty | hold | haz;
  assign issue = ~stall;
  assign bub   = haz & ~empty & ~hold;

  assign opcode = head.op;
  assign src1   = head.src1;
  assign src2   = head.src2;
  assign dest   = head.dest;

  assign resValid = s2v;
  assign resDest  = s2d;

  palu_issue_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .din    (din),
    .pop    (issue),
    .head   (head),
    .count  (count),
    .empty  (empty)
  );

  // lastValid/lastDest double as the entry stage of the
  // result tracker, giving the pipeline's three-edge latency.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lastValid   <= 1'b0;
      lastDest    <= '0;
      s1v         <= 1'b0;
      s1d         <= '0;
      s2v         <= 1'b0;
      s2d         <= '0;
      issueCount  <= '0;
      bubbleCount <= '0;
    end else begin
      lastValid <= issue;
      if (issue) begin
        lastDest   <= head.dest;
        issueCount <= issueCount + 1'b1;
      end
      s1v <= lastValid;
      s1d <= lastDest;
      s2v <= s1v;
      s2d <= s1d;
      if (bub && (bubbleCount != '1)) begin
        bubbleCount <= bubbleCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_palu_issue.sv
// tb_palu_issue: directed self-checking bench for palu_issue.
// Drives #1 after each rising edge, checks before the next one.
module tb_palu_issue;
  import palu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        inValid;
  logic        inReady;
  logic [2:0]  inOpcode;
  logic [2:0]  inSrc1;
  logic [2:0]  inSrc2;
  logic [2:0]  inDest;
  logic        hold;
  logic        stall;
  logic [2:0]  opcode;
  logic [2:0]  src1;
  logic [2:0]  src2;
  logic [2:0]  dest;
  logic        resValid;
  logic [2:0]  resDest;
  logic [15:0] issueCount;
  logic [15:0] bubbleCount;

  int nassert = 0;
  int nfail   = 0;

  palu_issue #(
    .DEPTH(4),
    .CW   (16)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .inOpcode   (inOpcode),
    .inSrc1     (inSrc1),
    .inSrc2     (inSrc2),
    .inDest     (inDest),
    .hold       (hold),
    .stall      (stall),
    .opcode     (opcode),
    .src1       (src1),
    .src2       (src2),
    .dest       (dest),
    .resValid   (resValid),
    .resDest    (resDest),
    .issueCount (issueCount),
    .bubbleCount(bubbleCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(
    input logic [2:0] op,
    input logic [2:0] s1,
    input logic [2:0] s2,
    input logic [2:0] d
  );
    inValid  = 1'b1;
    inOpcode = op;
    inSrc1   = s1;
    inSrc2   = s2;
    inDest   = d;
  endtask

  task automatic idle();
    inValid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    inValid  = 1'b0;
    inOpcode = '0;
    inSrc1   = '0;
    inSrc2   = '0;
    inDest   = '0;
    hold     = 1'b0;

    // reset then idle
    #12 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_stall", stall, 1);
      chk("idle_ready", inReady, 1);
      chk("idle_resv", resValid, 0);
    end
    chk("idle_icnt", issueCount, 0);
    chk("idle_bcnt", bubbleCount, 0);
    chk("idle_resd", resDest, 0);

    // independent stream
    offer(ADD, 3'd2, 3'd3, 3'd1);
    step();
    offer(SUB, 3'd5, 3'd6, 3'd4);
    chk("ind_st0", stall, 0);
    chk("ind_op0", opcode, ADD);
    chk("ind_d0", dest, 1);
    step();
    offer(NAND, 3'd2, 3'd5, 3'd7);
    chk("ind_st1", stall, 0);
    chk("ind_op1", opcode, SUB);
    step();
    idle();
    chk("ind_st2", stall, 0);
    chk("ind_op2", opcode, NAND);
    chk("ind_resv_early", resValid, 0);
    step();
    chk("ind_empty", stall, 1);
    chk("ind_icnt", issueCount, 3);
    chk("ind_bcnt", bubbleCount, 0);
    chk("ind_rv0", resValid, 1);
    chk("ind_rd0", resDest, 1);
    step();
    chk("ind_rv1", resValid, 1);
    chk("ind_rd1", resDest, 4);
    step();
    chk("ind_rv2", resValid, 1);
    chk("ind_rd2", resDest, 7);
    step();
    chk("ind_rv3", resValid, 0);

    // RAW hazard
    offer(ONE, 3'd0, 3'd0, 3'd2);
    step();
    offer(ADD, 3'd2, 3'd0, 3'd3);
    chk("raw_st0", stall, 0);
    chk("raw_op0", opcode, ONE);
    step();
    idle();
    chk("raw_bubble", stall, 1);
    chk("raw_bcnt0", bubbleCount, 0);
    step();
    chk("raw_st1", stall, 0);
    chk("raw_op1", opcode, ADD);
    chk("raw_bcnt1", bubbleCount, 1);
    step();
    chk("raw_st2", stall, 1);
    chk("raw_icnt", issueCount, 5);

    // no hazard when sources differ
    offer(ONE, 3'd0, 3'd0, 3'd2);
    step();
    offer(ADD, 3'd0, 3'd0, 3'd3);
    chk("nh_st0", stall, 0);
    step();
    idle();
    chk("nh_st1", stall, 0);
    chk("nh_op1", opcode, ADD);
    step();
    chk("nh_st2", stall, 1);
    chk("nh_bcnt", bubbleCount, 1);
    chk("nh_icnt", issueCount, 7);

    // fill under hold, then push/pop together
    hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("full_ready_pre", inReady, 1);
      offer(ADD, 3'd0, 3'd0, 3'(k + 1));
      step();
    end
    chk("full_ready", inReady, 0);
    chk("full_stall", stall, 1);
    offer(ADD, 3'd0, 3'd0, 3'd5);
    step();
    chk("full_ready2", inReady, 0);
    chk("full_icnt", issueCount, 7);
    hold = 1'b0;
    #1;
    chk("rel_st", stall, 0);
    chk("rel_ready", inReady, 0);
    chk("rel_d1", dest, 1);
    step();
    for (int k = 1; k < 4; k++) begin
      chk("pp_stall", stall, 0);
      chk("pp_ready", inReady, 1);
      chk("pp_dest", dest, 32'(k + 1));
      offer(ADD, 3'd0, 3'd0, 3'(k + 4));
      step();
    end
    idle();
    for (int k = 4; k < 7; k++) begin
      chk("drain_stall", stall, 0);
      chk("drain_dest", dest, 32'(k + 1));
      step();
    end
    chk("drain_end", stall, 1);
    chk("drain_icnt", issueCount, 14);
    chk("drain_bcnt", bubbleCount, 1);

    // hold over a hazard
    offer(ONE, 3'd0, 3'd0, 3'd2);
    step();
    offer(ADD, 3'd2, 3'd0, 3'd3);
    step();
    idle();
    hold = 1'b1;
    #1;
    chk("hh_st0", stall, 1);
    step();
    chk("hh_st1", stall, 1);
    step();
    chk("hh_st2", stall, 1);
    step();
    hold = 1'b0;
    #1;
    chk("hh_go", stall, 0);
    chk("hh_op", opcode, ADD);
    chk("hh_bcnt", bubbleCount, 1);
    step();
    chk("hh_st3", stall, 1);
    chk("hh_icnt", issueCount, 16);
    chk("hh_bcnt2", bubbleCount, 1);

    // mid-operation reset
    hold = 1'b1;
    offer(ADD, 3'd0, 3'd0, 3'd5);
    step();
    offer(ADD, 3'd0, 3'd0, 3'd6);
    step();
    offer(ADD, 3'd0, 3'd0, 3'd1);
    step();
    offer(ADD, 3'd0, 3'd0, 3'd2);
    step();
    hold = 1'b0;
    offer(ADD, 3'd0, 3'd0, 3'd3);
    step();
    idle();
    step();
    hold = 1'b1;
    #1;
    chk("mr_icnt_pre", issueCount, 18);
    chk("mr_ready_pre", inReady, 1);
    reset_n = 1'b0;
    #1;
    chk("mr_stall", stall, 1);
    chk("mr_resv", resValid, 0);
    chk("mr_resd", resDest, 0);
    chk("mr_ready", inReady, 1);
    chk("mr_icnt", issueCount, 0);
    chk("mr_bcnt", bubbleCount, 0);
    #2 reset_n = 1'b1;
    hold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mr_st_idle", stall, 1);
      chk("mr_rv_idle", resValid, 0);
    end
    chk("mr_icnt_idle", issueCount, 0);
    offer(SUB, 3'd1, 3'd2, 3'd4);
    step();
    idle();
    chk("mr_new_st", stall, 0);
    chk("mr_new_d", dest, 4);
    step();
    chk("mr_new_icnt", issueCount, 1);
    chk("mr_new_rv0", resValid, 0);
    step();
    chk("mr_new_rv1", resValid, 0);
    step();
    chk("mr_new_rv2", resValid, 1);
    chk("mr_new_rd", resDest, 4);
    step();
    chk("mr_new_rv3", resValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
